// File: rtl/ex_pkg.sv
// ex_pkg: shared encodings for the execute stage with the multiply/divide unit.
// Holds the funct codes, alu_op and forwarding selects, and the MDU state enum.
package ex_pkg;

    // funct field (imm[5:0]) encodings used when alu_op selects funct decode
    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_NOR   = 6'b100111;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    // alu_op encodings
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // forwarding selects; 2'b11 falls back to the register value
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // iterative multiply/divide unit states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ex_stage_mdu_if: ID/EX operand bus in, EX/MEM register bus out, plus stall.
// master = upstream pipeline/driver, slave = the execute stage.
interface ex_stage_mdu_if #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
);
    logic             in_valid;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  rs_data;
    logic [XLEN-1:0]  rt_data;
    logic [XLEN-1:0]  imm;
    logic [RADDR-1:0] rt_addr;
    logic [RADDR-1:0] rd_addr;
    logic             alu_src;
    logic             reg_dest;
    logic [1:0]       alu_op;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [XLEN-1:0]  mem_result;
    logic [XLEN-1:0]  wb_result;

    logic             stall;
    logic             out_valid;
    logic [XLEN-1:0]  out_result;
    logic [XLEN-1:0]  out_store_data;
    logic [RADDR-1:0] out_rd;
    logic             out_zero;
    logic [XLEN-1:0]  out_branch_target;
    logic             illegal_op;

    modport master (
        output in_valid, pc4, rs_data, rt_data, imm, rt_addr, rd_addr,
               alu_src, reg_dest, alu_op, fwd_a, fwd_b, mem_result, wb_result,
        input  stall, out_valid, out_result, out_store_data, out_rd,
               out_zero, out_branch_target, illegal_op
    );

    modport slave (
        input  in_valid, pc4, rs_data, rt_data, imm, rt_addr, rd_addr,
               alu_src, reg_dest, alu_op, fwd_a, fwd_b, mem_result, wb_result,
        output stall, out_valid, out_result, out_store_data, out_rd,
               out_zero, out_branch_target, illegal_op
    );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu: iterative multiply/divide unit with HI/LO.
// One bit per cycle for XLEN cycles in BUSY, then HI/LO are written on the
// edge leaving DONE. Signed ops run on magnitudes and fix signs at the end.
// Macro EX_DIV_EN: when defined the restoring divider is built; otherwise
// only multiply is accepted and a divide start is ignored.
module ex_mdu
    import ex_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            op_div,
    input  logic            op_unsigned,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN);

    mdu_state_e       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  acc_hi;     // partial product high half / remainder
    logic [XLEN-1:0]  acc_lo;     // multiplier / dividend-then-quotient
    logic [XLEN-1:0]  opnd;       // multiplicand / divisor magnitude
    logic             neg_lo;     // negate product or quotient at the end
    logic             go, last_step;
    logic             neg_a, neg_b;
    logic [XLEN-1:0]  mag_a, mag_b;
    logic [XLEN:0]    mul_sum;
    logic [2*XLEN-1:0] prod_mag, prod_res;
    logic [XLEN-1:0]  hi_res, lo_res;

`ifdef EX_DIV_EN
    logic             is_div;
    logic             neg_hi;     // remainder follows the dividend sign
    logic             div_zero;
    logic [XLEN-1:0]  dividend;
    logic [XLEN:0]    div_shift;
    logic             div_ge;
    logic [XLEN-1:0]  div_diff;

    assign go        = start;
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    // low bits of the full difference; the top bit is zero whenever div_ge
    assign div_diff  = div_shift[XLEN-1:0] - opnd;
`else
    assign go = start & ~op_div;
`endif

    assign neg_a     = ~op_unsigned & op_a[XLEN-1];
    assign neg_b     = ~op_unsigned & op_b[XLEN-1];
    assign mag_a     = neg_a ? -op_a : op_a;
    assign mag_b     = neg_b ? -op_b : op_b;
    assign mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
    assign last_step = (cnt == CNT_W'(XLEN - 1));
    assign busy      = (state != IDLE);

    // state register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // next-state: start -> XLEN iterations -> one write-back cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = BUSY;
            BUSY:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // final sign correction and divide-by-zero result
    always_comb begin
        prod_mag = {acc_hi, acc_lo};
        prod_res = neg_lo ? -prod_mag : prod_mag;
        hi_res   = prod_res[2*XLEN-1:XLEN];
        lo_res   = prod_res[XLEN-1:0];
`ifdef EX_DIV_EN
        if (is_div) begin
            if (div_zero) begin
                lo_res = '1;
                hi_res = dividend;
            end else begin
                lo_res = neg_lo ? -acc_lo : acc_lo;
                hi_res = neg_hi ? -acc_hi : acc_hi;
            end
        end
`endif
    end

    // operand capture, one iteration per BUSY cycle, HI/LO write-back
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_lo <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef EX_DIV_EN
            is_div   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            dividend <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (go) begin
                    cnt    <= '0;
                    acc_hi <= '0;
                    neg_lo <= neg_a ^ neg_b;
`ifdef EX_DIV_EN
                    is_div   <= op_div;
                    neg_hi   <= neg_a;
                    div_zero <= (op_b == '0);
                    dividend <= op_a;
                    if (op_div) begin
                        acc_lo <= mag_a;
                        opnd   <= mag_b;
                    end else
`endif
                    begin
                        acc_lo <= mag_b;
                        opnd   <= mag_a;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
`ifdef EX_DIV_EN
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff : div_shift[XLEN-1:0];
                        acc_lo <= {acc_lo[XLEN-2:0], div_ge};
                    end else
`endif
                    begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                DONE: begin
                    hi <= hi_res;
                    lo <= lo_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ex_stage_mdu.sv
// ex_stage_mdu: execute stage with forwarding, ALU, branch target, an
// iterative multiply/divide unit and the EX/MEM output register.
// Macro EX_DIV_EN: when defined div/divu run on the MDU; otherwise they
// pulse illegal_op, leave HI/LO alone and do not stall.
module ex_stage_mdu
    import ex_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RADDR = 5
) (
    input logic           clock,
    input logic           reset,
    ex_stage_mdu_if.slave bus
);

    logic [XLEN-1:0]  op_a, fwd_b_val, op_b, alu_result, hi, lo;
    logic [5:0]       funct;
    logic             is_funct, is_mul, is_div, is_mdu, div_illegal;
    logic             alu_illegal, accept, mdu_start, mdu_busy;

    logic             valid_q, zero_q, illegal_q;
    logic [XLEN-1:0]  result_q, store_q, target_q;
    logic [RADDR-1:0] rd_q;

    assign funct    = bus.imm[5:0];
    assign is_funct = (bus.alu_op == ALU_FUNCT);
    assign is_mul   = is_funct && (funct == FUNCT_MULT || funct == FUNCT_MULTU);
    assign is_div   = is_funct && (funct == FUNCT_DIV  || funct == FUNCT_DIVU);
`ifdef EX_DIV_EN
    assign is_mdu      = is_mul | is_div;
    assign div_illegal = 1'b0;
`else
    assign is_mdu      = is_mul;
    assign div_illegal = is_div;
`endif
    // nothing is consumed while the MDU owns the stage
    assign accept    = bus.in_valid & ~mdu_busy;
    assign mdu_start = accept & is_mdu;

    // forwarding muxes; the unused select code behaves as the register path
    always_comb begin
        case (bus.fwd_a)
            FWD_MEM: op_a = bus.mem_result;
            FWD_WB:  op_a = bus.wb_result;
            default: op_a = bus.rs_data;
        endcase
        case (bus.fwd_b)
            FWD_MEM: fwd_b_val = bus.mem_result;
            FWD_WB:  fwd_b_val = bus.wb_result;
            default: fwd_b_val = bus.rt_data;
        endcase
        op_b = bus.alu_src ? bus.imm : fwd_b_val;
    end

    // ALU; MDU codes produce nothing here, unknown functs give 0 + illegal
    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (bus.alu_op)
            ALU_SUB:   alu_result = op_a - op_b;
            ALU_FUNCT: begin
                case (funct)
                    FUNCT_ADD:  alu_result = op_a + op_b;
                    FUNCT_SUB:  alu_result = op_a - op_b;
                    FUNCT_AND:  alu_result = op_a & op_b;
                    FUNCT_OR:   alu_result = op_a | op_b;
                    FUNCT_NOR:  alu_result = ~(op_a | op_b);
                    FUNCT_SLT:  alu_result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
                    FUNCT_MFHI: alu_result = hi;
                    FUNCT_MFLO: alu_result = lo;
                    FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: ;
                    default:    alu_illegal = 1'b1;
                endcase
            end
            default:   alu_result = op_a + op_b;
        endcase
    end

    ex_mdu #(.XLEN(XLEN)) u_mdu (
        .clock       (clock),
        .reset       (reset),
        .start       (mdu_start),
        .op_div      (funct[1]),
        .op_unsigned (funct[0]),
        .op_a        (op_a),
        .op_b        (op_b),
        .busy        (mdu_busy),
        .hi          (hi),
        .lo          (lo)
    );

    // EX/MEM register: bubbles and MDU starts clear valid and hold the data
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            store_q   <= '0;
            target_q  <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            if (accept && !is_mdu) begin
                if (div_illegal) begin
                    illegal_q <= 1'b1;
                end else begin
                    valid_q   <= 1'b1;
                    illegal_q <= alu_illegal;
                    result_q  <= alu_result;
                    zero_q    <= (alu_result == '0);
                    store_q   <= fwd_b_val;
                    rd_q      <= bus.reg_dest ? bus.rd_addr : bus.rt_addr;
                    target_q  <= bus.pc4 + (bus.imm << 2);
                end
            end
        end
    end

    assign bus.stall             = mdu_busy;
    assign bus.out_valid         = valid_q;
    assign bus.out_result        = result_q;
    assign bus.out_store_data    = store_q;
    assign bus.out_rd            = rd_q;
    assign bus.out_zero          = zero_q;
    assign bus.out_branch_target = target_q;
    assign bus.illegal_op        = illegal_q;

endmodule
